// File: rtl/ysyx_rob_commit.sv
// In-order reorder buffer: program-order dispatch, out-of-order writeback by
// tag, in-order single retire per cycle into a registered regfile write port.

`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

module ysyx_rob_commit #(
    parameter  int unsigned XLEN     = `YSYX_XLEN,
    parameter  int unsigned ROB_SIZE = 4,
    localparam int unsigned TAG_W    = $clog2(ROB_SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             dis_valid,
    output logic             dis_ready,
    input  logic [4:0]       dis_rd,
    output logic [TAG_W-1:0] dis_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [XLEN-1:0]  wb_data,
    output logic             write_en,
    output logic [4:0]       waddr,
    output logic [XLEN-1:0]  wdata,
    output logic             rob_empty,
    output logic [TAG_W:0]   rob_count
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0] ent_valid;
    logic [ROB_SIZE-1:0] ent_done;
    logic [4:0]          ent_rd   [ROB_SIZE];
    logic [XLEN-1:0]     ent_data [ROB_SIZE];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic fire;
    logic retire;
    logic wb_hit;

    // Handshake and retire decisions, all from registered state only
    always_comb begin
        dis_ready = (count != FULL_COUNT);
        fire      = dis_valid & dis_ready;
        retire    = ent_valid[head] & ent_done[head];
        wb_hit    = wb_valid & ent_valid[wb_tag];
        dis_tag   = tail;
        rob_empty = (count == '0);
        rob_count = count;
    end

    // Entry status bits, pointers, occupancy and the registered write port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_valid <= '0;
            ent_done  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            write_en  <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else if (flush) begin
            ent_valid <= '0;
            ent_done  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            write_en  <= 1'b0;
        end else begin
            if (wb_hit) begin
                ent_done[wb_tag] <= 1'b1;
            end
            if (retire) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
                write_en        <= (ent_rd[head] != 5'd0);
                waddr           <= ent_rd[head];
                wdata           <= ent_data[head];
            end else begin
                write_en <= 1'b0;
            end
            // tail only equals wb_tag of a valid entry when full, so a fire
            // never collides with the writeback above
            if (fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + 1'b1;
            end
            if (fire && !retire) begin
                count <= count + 1'b1;
            end else if (retire && !fire) begin
                count <= count - 1'b1;
            end
        end
    end

    // Payload storage; contents are only meaningful while the entry is valid
    always_ff @(posedge clock) begin
        if (fire) begin
            ent_rd[tail] <= dis_rd;
        end
        if (wb_hit) begin
            ent_data[wb_tag] <= wb_data;
        end
    end

endmodule

// File: tb/tb_ysyx_rob_commit.sv
// Self-checking bench for ysyx_rob_commit: directed scenarios followed by a
// random phase, all compared against a queue-based program-order model.

module tb_ysyx_rob_commit;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned ROB_SIZE = 4;
    localparam int unsigned TAG_W    = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic             dis_valid;
    logic             dis_ready;
    logic [4:0]       dis_rd;
    logic [TAG_W-1:0] dis_tag;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [XLEN-1:0]  wb_data;
    logic             write_en;
    logic [4:0]       waddr;
    logic [XLEN-1:0]  wdata;
    logic             rob_empty;
    logic [TAG_W:0]   rob_count;

    ysyx_rob_commit #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .dis_valid (dis_valid),
        .dis_ready (dis_ready),
        .dis_rd    (dis_rd),
        .dis_tag   (dis_tag),
        .wb_valid  (wb_valid),
        .wb_tag    (wb_tag),
        .wb_data   (wb_data),
        .write_en  (write_en),
        .waddr     (waddr),
        .wdata     (wdata),
        .rob_empty (rob_empty),
        .rob_count (rob_count)
    );

    always #5 clock = ~clock;

    // Reference model: in-flight instructions in program order
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          done;
        logic [63:0] data;
    } ent_t;

    ent_t        q[$];
    int          next_tag;
    bit          e_we;
    logic [4:0]  e_waddr;
    logic [63:0] e_wdata;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        next_tag = 0;
        e_we     = 1'b0;
        e_waddr  = '0;
        e_wdata  = '0;
    endtask

    task automatic chk_all(input string where);
        chk({where, ".write_en"},  write_en,  e_we);
        chk({where, ".waddr"},     waddr,     e_waddr);
        chk({where, ".wdata"},     wdata,     e_wdata);
        chk({where, ".rob_count"}, rob_count, q.size());
        chk({where, ".rob_empty"}, rob_empty, q.size() == 0);
        chk({where, ".dis_ready"}, dis_ready, q.size() < ROB_SIZE);
        chk({where, ".dis_tag"},   dis_tag,   next_tag);
    endtask

    // One clock cycle: drive inputs, predict the edge, then compare after it
    task automatic step(input bit dv, input logic [4:0] rd, input bit wv,
                        input int wt, input logic [63:0] wd, input bit fl);
        int   sz;
        bit   ret;
        ent_t h;
        dis_valid = dv;
        dis_rd    = rd;
        wb_valid  = wv;
        wb_tag    = TAG_W'(wt);
        wb_data   = wd;
        flush     = fl;
        #1;
        chk("pre.dis_ready", dis_ready, q.size() < ROB_SIZE);
        chk("pre.dis_tag",   dis_tag,   next_tag);
        sz = q.size();
        if (fl) begin
            q.delete();
            next_tag = 0;
            e_we     = 1'b0;
        end else begin
            ret = (sz > 0) && q[0].done;
            if (ret) h = q[0];
            if (wv) begin
                foreach (q[i]) if (q[i].tag == wt) begin
                    q[i].done = 1'b1;
                    q[i].data = wd;
                end
            end
            if (ret) begin
                void'(q.pop_front());
                e_we    = (h.rd != 5'd0);
                e_waddr = h.rd;
                e_wdata = h.data;
            end else begin
                e_we = 1'b0;
            end
            if (dv && sz < ROB_SIZE) begin
                q.push_back('{tag: next_tag, rd: rd, done: 1'b0, data: '0});
                next_tag = (next_tag + 1) % ROB_SIZE;
            end
        end
        @(posedge clock);
        #1;
        chk_all("post");
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic dispatch(input logic [4:0] rd);
        step(1'b1, rd, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic wb(input int t, input logic [63:0] d);
        step(1'b0, 5'd0, 1'b1, t, d, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, 5'd0, 1'b0, 0, '0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; dis_valid = 1'b0; dis_rd = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
        m_reset();

        // 1. reset state
        repeat (2) @(posedge clock);
        #1;
        chk_all("reset");
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        chk_all("reset_rel");
        chk("reset.dis_tag0", dis_tag, 0);

        // 2. in-order flow: result visible exactly one cycle after the wb edge
        dispatch(5'd5);
        wb(0, 64'h1234);
        chk("flow.no_bypass", write_en, 1'b0);
        idle();
        chk("flow.we", write_en, 1'b1);
        chk("flow.waddr", waddr, 5);
        chk("flow.wdata", wdata, 64'h1234);
        idle();
        chk("flow.we_drop", write_en, 1'b0);

        // 3. out-of-order completion retires in program order
        do_flush();
        dispatch(5'd1); dispatch(5'd2); dispatch(5'd3);
        wb(2, 64'hC); wb(1, 64'hB);
        chk("ooo.hold", write_en, 1'b0);
        wb(0, 64'hA);
        idle(); chk("ooo.c1", waddr, 1); chk("ooo.d1", wdata, 64'hA);
        idle(); chk("ooo.c2", waddr, 2); chk("ooo.d2", wdata, 64'hB);
        idle(); chk("ooo.c3", waddr, 3); chk("ooo.d3", wdata, 64'hC);
        idle(); chk("ooo.empty", rob_empty, 1'b1);

        // 4. full and wrap
        do_flush();
        dispatch(5'd10); dispatch(5'd11); dispatch(5'd12); dispatch(5'd13);
        dispatch(5'd14);
        chk("full.ready", dis_ready, 1'b0);
        chk("full.count", rob_count, 4);
        wb(0, 64'h55);
        idle();
        chk("wrap.ready", dis_ready, 1'b1);
        chk("wrap.tag", dis_tag, 0);
        chk("wrap.count", rob_count, 3);

        // 5. x0 destination and writeback to an unallocated tag
        do_flush();
        dispatch(5'd0);
        wb(0, 64'h77);
        idle();
        chk("x0.we", write_en, 1'b0);
        chk("x0.count", rob_count, 0);
        wb(1, 64'h99);
        dispatch(5'd7);
        idle(); idle();
        chk("badwb.count", rob_count, 1);
        chk("badwb.we", write_en, 1'b0);

        // 6a. flush beats same-cycle dispatch and writeback
        do_flush();
        dispatch(5'd4); dispatch(5'd6); dispatch(5'd8);
        wb(1, 64'hAB);
        step(1'b1, 5'd9, 1'b1, 0, 64'hCD, 1'b1);
        chk("flush.count", rob_count, 0);
        repeat (3) begin idle(); chk("flush.we", write_en, 1'b0); end

        // 6b. same scenario, asynchronous reset mid-cycle
        dispatch(5'd4); dispatch(5'd6); dispatch(5'd8);
        wb(1, 64'hAB);
        dis_valid = 1'b1; dis_rd = 5'd9; wb_valid = 1'b1; wb_tag = '0;
        reset = 1'b0;
        m_reset();
        #1;
        chk_all("areset");
        chk("areset.count", rob_count, 0);
        @(posedge clock);
        #1;
        chk_all("areset_hold");
        dis_valid = 1'b0; wb_valid = 1'b0;
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        repeat (3) begin idle(); chk("areset.we", write_en, 1'b0); end

        // random phase
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, ROB_SIZE - 1),
                 {$urandom, $urandom}, $urandom_range(0, 99) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
